// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single main_mem data port between the LSU (port 0) and the loader/DMA (port 1).
// Define DM_ARB_RR_EN for strict round-robin; the default build is fixed priority with anti-starvation.
module dm_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_p0_req,
  input  logic              i_p0_we,
  input  logic [3:0]        i_p0_ben,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [31:0]       i_p0_wdata,
  output logic              o_p0_gnt,
  output logic              o_p0_rvalid,
  input  logic              i_p1_req,
  input  logic              i_p1_we,
  input  logic [3:0]        i_p1_ben,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [31:0]       i_p1_wdata,
  output logic              o_p1_gnt,
  output logic              o_p1_rvalid,
  output logic [31:0]       o_rdata,
  output logic              o_dm_ren,
  output logic              o_dm_wen,
  output logic [3:0]        o_dm_ben,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [31:0]       o_dm_wdata,
  input  logic [31:0]       i_dm_rdata,
  input  logic              i_mem_ready
);

  logic issue_ok;
  logic p1_wins;
  logic gnt0;
  logic gnt1;
  logic tag_valid;
  logic tag_port;

  // Grants are held off during reset as well as while main_mem is busy.
  assign issue_ok = i_rst_n & i_mem_ready;

`ifdef DM_ARB_RR_EN
  logic last_gnt;

  always_comb begin
    p1_wins = i_p1_req & (~i_p0_req | ~last_gnt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    p1_wins = i_p1_req & (~i_p0_req | (starve_cnt == CNT_MAX));
  end

  // Counts p1 losses; frozen while main_mem stalls so a stall never costs p1 its place.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (i_mem_ready) begin
      if (!i_p1_req || gnt1) begin
        starve_cnt <= '0;
      end else if (gnt0 && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`endif

  assign gnt1     = issue_ok & p1_wins;
  assign gnt0     = issue_ok & i_p0_req & ~p1_wins;
  assign o_p0_gnt = gnt0;
  assign o_p1_gnt = gnt1;

  always_comb begin
    o_dm_ren   = 1'b0;
    o_dm_wen   = 1'b0;
    o_dm_ben   = 4'b0000;
    o_dm_addr  = i_p0_addr;
    o_dm_wdata = i_p0_wdata;
    if (gnt1) begin
      o_dm_ren   = ~i_p1_we;
      o_dm_wen   = i_p1_we;
      o_dm_ben   = i_p1_ben;
      o_dm_addr  = i_p1_addr;
      o_dm_wdata = i_p1_wdata;
    end else if (gnt0) begin
      o_dm_ren   = ~i_p0_we;
      o_dm_wen   = i_p0_we;
      o_dm_ben   = i_p0_ben;
    end
  end

  // Return tag tracks which port owns the data main_mem presents next cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tag_valid <= 1'b0;
      tag_port  <= 1'b0;
    end else begin
      tag_valid <= o_dm_ren;
      tag_port  <= gnt1;
    end
  end

  assign o_p0_rvalid = i_rst_n & tag_valid & ~tag_port;
  assign o_p1_rvalid = i_rst_n & tag_valid & tag_port;
  assign o_rdata     = i_dm_rdata;

endmodule
